// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, LSB-first data,
// optional even parity, stop bit, each held for CLKS_PER_BIT clocks.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_baud;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [DATA_W-1:0]   r_shift;
    logic                r_parity;
    logic                r_txd;
    logic                r_busy;
    logic                r_done;

    logic                w_baud_last;
    logic [DATA_W-1:0]   w_shift_next;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    assign w_baud_last  = (r_baud == BAUD_LAST);
    assign w_shift_next = r_shift >> 1;

    assign din_ready = (r_state == S_IDLE);
    assign txd       = r_txd;
    assign busy      = r_busy;
    assign done      = r_done;

    // Frame sequencer: state, bit timing, shift register and registered line outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_baud    <= {CNT_W{1'b0}};
            r_bit_idx <= {IDX_W{1'b0}};
            r_shift   <= {DATA_W{1'b0}};
            r_parity  <= 1'b0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_txd  <= 1'b1;
                    r_busy <= 1'b0;
                    if (din_valid) begin
                        r_shift   <= din;
                        r_parity  <= even_parity(din);
                        r_baud    <= {CNT_W{1'b0}};
                        r_bit_idx <= {IDX_W{1'b0}};
                        r_state   <= S_START;
                        r_txd     <= 1'b0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud  <= {CNT_W{1'b0}};
                        r_state <= S_DATA;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud  <= {CNT_W{1'b0}};
                        r_shift <= w_shift_next;
                        if (r_bit_idx == IDX_LAST) begin
                            r_bit_idx <= {IDX_W{1'b0}};
                            if (PARITY_EN != 0) begin
                                r_state <= S_PARITY;
                                r_txd   <= r_parity;
                            end else begin
                                r_state <= S_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_txd     <= w_shift_next[0];
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (w_baud_last) begin
                        r_baud  <= {CNT_W{1'b0}};
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    // Busy drops and done pulses on the edge the stop bit completes.
                    if (w_baud_last) begin
                        r_baud  <= {CNT_W{1'b0}};
                        r_state <= S_IDLE;
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= {CNT_W{1'b0}};
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
